// File: rtl/can_clic_arbiter_if.sv
// Interrupt entry vector in, registered winning request out.
interface can_clic_arbiter_if #(
    parameter int N_ENTRIES = 4,
    parameter int PRIO_W    = 2,
    parameter int ENTRY_W   = PRIO_W + 1,
    parameter int IDX_W     = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
);
    logic [N_ENTRIES*ENTRY_W-1:0] entries;
    logic                         is_interrupt;
    logic [IDX_W-1:0]             index;
    logic [PRIO_W-1:0]            prio;

    modport master (
        output entries,
        input  is_interrupt,
        input  index,
        input  prio
    );

    modport slave (
        input  entries,
        output is_interrupt,
        output index,
        output prio
    );
endinterface

// File: rtl/can_clic_arbiter.sv
// CLIC-style interrupt arbiter: balanced comparison tree selects the highest
// priority pending entry (lowest index on ties), registered once.
module can_clic_arbiter #(
    parameter int N_ENTRIES = 4,
    parameter int PRIO_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    can_clic_arbiter_if.slave   bus
);
    localparam int ENTRY_W = PRIO_W + 1;
    localparam int IDX_W   = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
    localparam int LEAVES  = 1 << IDX_W;

    // Heap-ordered tree: node k has children 2k and 2k+1, leaves at LEAVES+i.
    logic              w_vld  [1:2*LEAVES-1];
    logic [PRIO_W-1:0] w_prio [1:2*LEAVES-1];
    logic [IDX_W-1:0]  w_idx  [1:2*LEAVES-1];

    for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
        if (i < N_ENTRIES) begin : g_real
            assign w_vld[LEAVES+i]  = bus.entries[(N_ENTRIES-1-i)*ENTRY_W];
            assign w_prio[LEAVES+i] = bus.entries[(N_ENTRIES-1-i)*ENTRY_W+1 +: PRIO_W];
        end else begin : g_pad
            assign w_vld[LEAVES+i]  = 1'b0;
            assign w_prio[LEAVES+i] = '0;
        end
        assign w_idx[LEAVES+i] = IDX_W'(i);
    end

    // Left child holds the lower indices, so it wins on equal priority.
    for (genvar k = 1; k < LEAVES; k++) begin : g_node
        logic w_left_wins;
        assign w_left_wins = w_vld[2*k] &&
                             (!w_vld[2*k+1] || (w_prio[2*k] >= w_prio[2*k+1]));
        assign w_vld[k]  = w_vld[2*k] | w_vld[2*k+1];
        assign w_prio[k] = w_left_wins ? w_prio[2*k] : w_prio[2*k+1];
        assign w_idx[k]  = w_left_wins ? w_idx[2*k]  : w_idx[2*k+1];
    end

    logic              w_irq_p0;
    logic [PRIO_W-1:0] w_prio_p0;
    logic [IDX_W-1:0]  w_idx_p0;

    assign w_irq_p0  = w_vld[1];
    assign w_prio_p0 = w_vld[1] ? w_prio[1] : '0;
    assign w_idx_p0  = w_vld[1] ? w_idx[1]  : '0;

    // ---- p0 -> p1: registered request ----
    logic              r_irq_p1;
    logic [PRIO_W-1:0] r_prio_p1;
    logic [IDX_W-1:0]  r_idx_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq_p1  <= 1'b0;
            r_prio_p1 <= '0;
            r_idx_p1  <= '0;
        end else begin
            r_irq_p1  <= w_irq_p0;
            r_prio_p1 <= w_prio_p0;
            r_idx_p1  <= w_idx_p0;
        end
    end

    assign bus.is_interrupt = r_irq_p1;
    assign bus.prio         = r_prio_p1;
    assign bus.index        = r_idx_p1;
endmodule

// File: tb/tb_can_clic_arbiter.sv
// Directed-vector bench for can_clic_arbiter at default parameters.
module tb_can_clic_arbiter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    can_clic_arbiter_if #(.N_ENTRIES(4), .PRIO_W(2)) bus ();

    can_clic_arbiter #(.N_ENTRIES(4), .PRIO_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic irq, input logic [1:0] idx,
                           input logic [1:0] pr);
        chk({tag, ".irq"},  32'(bus.is_interrupt), 32'(irq));
        chk({tag, ".idx"},  32'(bus.index),        32'(idx));
        chk({tag, ".prio"}, 32'(bus.prio),         32'(pr));
    endtask

    // Drive at negedge, sample 1 time unit after the following posedge.
    task automatic apply(input string tag, input logic [11:0] ent, input logic irq,
                         input logic [1:0] idx, input logic [1:0] pr);
        @(negedge clk);
        bus.entries = ent;
        @(posedge clk);
        #1;
        chk_out(tag, irq, idx, pr);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b0;
        bus.entries = 12'b001_001_001_001;

        // Reset asserted before any clock edge.
        #1 rst = 1'b1;
        #1 chk_out("rst_async", 1'b0, 2'd0, 2'd0);
        @(posedge clk); #1;
        chk_out("rst_hold", 1'b0, 2'd0, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk_out("rst_release", 1'b1, 2'd0, 2'd0);

        apply("single_last",  12'b000_000_000_001, 1'b1, 2'd3, 2'd0);
        apply("prio_sel_a",   12'b000_011_101_001, 1'b1, 2'd2, 2'd2);
        apply("prio_sel_b",   12'b111_011_101_001, 1'b1, 2'd0, 2'd3);
        apply("not_pending",  12'b110_100_010_000, 1'b0, 2'd0, 2'd0);
        apply("tie_break",    12'b000_101_000_101, 1'b1, 2'd1, 2'd2);
        apply("all_same",     12'b011_011_011_011, 1'b1, 2'd0, 2'd1);
        apply("last_top",     12'b000_000_000_111, 1'b1, 2'd3, 2'd3);
        apply("mid_max",      12'b101_111_001_111, 1'b1, 2'd1, 2'd3);

        // Back-to-back: outputs must hold until the edge, then update.
        @(negedge clk);
        bus.entries = 12'b000_000_000_001;
        #1 chk_out("b2b_hold0", 1'b1, 2'd1, 2'd3);
        @(posedge clk); #1;
        chk_out("b2b_1", 1'b1, 2'd3, 2'd0);
        @(negedge clk);
        bus.entries = 12'b000_011_101_001;
        #1 chk_out("b2b_hold1", 1'b1, 2'd3, 2'd0);
        @(posedge clk); #1;
        chk_out("b2b_2", 1'b1, 2'd2, 2'd2);
        @(negedge clk);
        bus.entries = 12'b110_100_010_000;
        #1 chk_out("b2b_hold2", 1'b1, 2'd2, 2'd2);
        @(posedge clk); #1;
        chk_out("b2b_3", 1'b0, 2'd0, 2'd0);

        // Mid-stream reset clears outputs between edges.
        apply("pre_rst", 12'b111_011_101_001, 1'b1, 2'd0, 2'd3);
        #2 rst = 1'b1;
        #1 chk_out("rst_mid", 1'b0, 2'd0, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.entries = 12'b000_000_011_000;
        @(posedge clk); #1;
        chk_out("post_rst", 1'b1, 2'd2, 2'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
